// File: rtl/cpu_run_dump_if.sv
// Dump stream interface: one word per valid/ready handshake.
interface cpu_run_dump_if #(
  parameter int unsigned DATA_W = 19,
  parameter int unsigned MEM_AW = 6
);
  logic              dump_valid;
  logic              dump_ready;
  logic [DATA_W-1:0] dump_data;
  logic              dump_is_mem;
  logic [MEM_AW-1:0] dump_addr;
  logic              dump_last;

  modport master (
    output dump_valid, dump_data, dump_is_mem, dump_addr, dump_last,
    input  dump_ready
  );

  modport slave (
    input  dump_valid, dump_data, dump_is_mem, dump_addr, dump_last,
    output dump_ready
  );
endinterface

// File: rtl/cpu_run_dump.sv
// Run controller and state dumper for the 19-bit CPU.
// Holds the CPU in reset, runs it for a bounded budget or until halt, then
// streams the register file and (when CPU_RUN_DUMP_MEM_EN is defined) the
// data memory over the dump interface. All outputs are registered.
module cpu_run_dump #(
  parameter int unsigned DATA_W       = 19,
  parameter int unsigned REG_COUNT    = 8,
  parameter int unsigned REG_AW       = 3,
  parameter int unsigned MEM_DEPTH    = 64,
  parameter int unsigned MEM_AW       = 6,
  parameter int unsigned RESET_CYCLES = 1,
  parameter int unsigned RUN_CYCLES   = 100
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              cpu_halted,
  output logic              cpu_reset,
  output logic              cpu_clk_en,
  output logic [REG_AW-1:0] dbg_reg_addr,
  input  logic [DATA_W-1:0] dbg_reg_data,
  output logic [MEM_AW-1:0] dbg_mem_addr,
  input  logic [DATA_W-1:0] dbg_mem_data,
  cpu_run_dump_if.master    dump,
  output logic              busy,
  output logic              done,
  output logic [31:0]       run_count
);

  localparam int unsigned RC_W  = $clog2(RESET_CYCLES + 1);
  localparam int unsigned IDX_W = (MEM_AW > REG_AW) ? MEM_AW : REG_AW;

  typedef enum logic [2:0] {
    IDLE, RST, RUN, REG_RD, REG_OUT, MEM_RD, MEM_OUT, DONE
  } state_t;

  state_t            state_q, state_d;
  logic [RC_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [31:0]       run_count_q, run_count_d;
  logic [REG_AW-1:0] reg_addr_q, reg_addr_d;
  logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              is_mem_q, is_mem_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic              last_q, last_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic              clk_en_q, clk_en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

`ifndef CPU_RUN_DUMP_MEM_EN
  // Memory phase is compiled out; its read data and depth have no consumer.
  logic unused_mem;
  assign unused_mem = ^{dbg_mem_data, 32'(MEM_DEPTH)};
`endif

  // State and registered output flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      run_count_q <= '0;
      reg_addr_q  <= '0;
      mem_addr_q  <= '0;
      valid_q     <= 1'b0;
      data_q      <= '0;
      is_mem_q    <= 1'b0;
      addr_q      <= '0;
      last_q      <= 1'b0;
      cpu_reset_q <= 1'b1;
      clk_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      run_count_q <= run_count_d;
      reg_addr_q  <= reg_addr_d;
      mem_addr_q  <= mem_addr_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      is_mem_q    <= is_mem_d;
      addr_q      <= addr_d;
      last_q      <= last_d;
      cpu_reset_q <= cpu_reset_d;
      clk_en_q    <= clk_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Next-state and next-output logic; CPU controls decode from the next state.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    run_count_d = run_count_q;
    reg_addr_d  = reg_addr_q;
    mem_addr_d  = mem_addr_q;
    valid_d     = valid_q;
    data_d      = data_q;
    is_mem_d    = is_mem_q;
    addr_d      = addr_q;
    last_d      = last_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d     = RST;
          cnt_d       = RC_W'(RESET_CYCLES);
          run_count_d = '0;
        end
      end
      RST: begin
        if (cnt_q <= RC_W'(1)) state_d = RUN;
        else                   cnt_d   = cnt_q - RC_W'(1);
      end
      RUN: begin
        run_count_d = (&run_count_q) ? run_count_q : run_count_q + 32'd1;
        if (run_count_d >= RUN_CYCLES || cpu_halted) begin
          state_d    = REG_RD;
          idx_d      = '0;
          reg_addr_d = '0;
        end
      end
      REG_RD: begin
        // Address was presented last cycle; read data is valid now.
        state_d  = REG_OUT;
        valid_d  = 1'b1;
        data_d   = dbg_reg_data;
        is_mem_d = 1'b0;
        addr_d   = MEM_AW'(idx_q);
`ifdef CPU_RUN_DUMP_MEM_EN
        last_d   = 1'b0;
`else
        last_d   = (idx_q == IDX_W'(REG_COUNT - 1));
`endif
      end
      REG_OUT: begin
        if (dump.dump_ready) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          if (idx_q == IDX_W'(REG_COUNT - 1)) begin
`ifdef CPU_RUN_DUMP_MEM_EN
            state_d    = MEM_RD;
            idx_d      = '0;
            mem_addr_d = '0;
`else
            state_d    = DONE;
`endif
          end else begin
            state_d    = REG_RD;
            idx_d      = idx_q + IDX_W'(1);
            reg_addr_d = REG_AW'(idx_q + IDX_W'(1));
          end
        end
      end
`ifdef CPU_RUN_DUMP_MEM_EN
      MEM_RD: begin
        state_d  = MEM_OUT;
        valid_d  = 1'b1;
        data_d   = dbg_mem_data;
        is_mem_d = 1'b1;
        addr_d   = MEM_AW'(idx_q);
        last_d   = (idx_q == IDX_W'(MEM_DEPTH - 1));
      end
      MEM_OUT: begin
        if (dump.dump_ready) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          if (idx_q == IDX_W'(MEM_DEPTH - 1)) begin
            state_d = DONE;
          end else begin
            state_d    = MEM_RD;
            idx_d      = idx_q + IDX_W'(1);
            mem_addr_d = MEM_AW'(idx_q + IDX_W'(1));
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    cpu_reset_d = (state_d == IDLE) || (state_d == RST);
    clk_en_d    = (state_d == RST) || (state_d == RUN);
    busy_d      = (state_d != IDLE) && (state_d != DONE);
    done_d      = (state_d == DONE);
  end

  assign cpu_reset        = cpu_reset_q;
  assign cpu_clk_en       = clk_en_q;
  assign dbg_reg_addr     = reg_addr_q;
  assign dbg_mem_addr     = mem_addr_q;
  assign dump.dump_valid  = valid_q;
  assign dump.dump_data   = data_q;
  assign dump.dump_is_mem = is_mem_q;
  assign dump.dump_addr   = addr_q;
  assign dump.dump_last   = last_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign run_count        = run_count_q;

endmodule

// File: tb/tb_cpu_run_dump.sv
// Scoreboard bench for cpu_run_dump: stimulus queues expected dump words,
// a monitor pops and compares them on every handshake.
module tb_cpu_run_dump;
  localparam int unsigned DATA_W     = 19;
  localparam int unsigned REG_COUNT  = 8;
  localparam int unsigned REG_AW     = 3;
  localparam int unsigned MEM_DEPTH  = 64;
  localparam int unsigned MEM_AW     = 6;
  localparam int unsigned RUN_CYCLES = 100;
`ifdef CPU_RUN_DUMP_MEM_EN
  localparam bit          HAS_MEM    = 1'b1;
  localparam int unsigned NWORDS     = REG_COUNT + MEM_DEPTH;
  localparam int unsigned RST_TGT    = 20;
`else
  localparam bit          HAS_MEM    = 1'b0;
  localparam int unsigned NWORDS     = REG_COUNT;
  localparam int unsigned RST_TGT    = 5;
`endif

  typedef logic [DATA_W+MEM_AW+1:0] word_t;

  logic              clk = 1'b0;
  logic              reset, start, cpu_halted;
  logic              cpu_reset, cpu_clk_en, busy, done;
  logic [REG_AW-1:0] dbg_reg_addr;
  logic [MEM_AW-1:0] dbg_mem_addr;
  logic [DATA_W-1:0] dbg_reg_data, dbg_mem_data;
  logic [31:0]       run_count;

  logic [DATA_W-1:0] regs [REG_COUNT];
  logic [DATA_W-1:0] mem  [MEM_DEPTH];

  word_t exp_q [$];
  int    total = 0, bad = 0;
  int    words_seen = 0, rst_cyc = 0, run_cyc = 0;
  bit    rand_ready = 1'b0;

  always #5 clk = ~clk;

  cpu_run_dump_if #(.DATA_W(DATA_W), .MEM_AW(MEM_AW)) dif ();

  cpu_run_dump #(
    .DATA_W(DATA_W), .REG_COUNT(REG_COUNT), .REG_AW(REG_AW),
    .MEM_DEPTH(MEM_DEPTH), .MEM_AW(MEM_AW), .RESET_CYCLES(1),
    .RUN_CYCLES(RUN_CYCLES)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .cpu_halted(cpu_halted),
    .cpu_reset(cpu_reset), .cpu_clk_en(cpu_clk_en),
    .dbg_reg_addr(dbg_reg_addr), .dbg_reg_data(dbg_reg_data),
    .dbg_mem_addr(dbg_mem_addr), .dbg_mem_data(dbg_mem_data),
    .dump(dif), .busy(busy), .done(done), .run_count(run_count)
  );

  // CPU debug ports: data follows the registered address within the cycle.
  assign dbg_reg_data = regs[dbg_reg_addr];
  assign dbg_mem_data = mem[dbg_mem_addr];

  word_t word_now;
  assign word_now = {dif.dump_last, dif.dump_is_mem, dif.dump_addr, dif.dump_data};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load_model(input int seed);
    for (int i = 0; i < int'(REG_COUNT); i++)
      regs[i] = DATA_W'((i * 32'h2F1 + seed * 32'h1357) ^ 32'h5A5A5);
    for (int i = 0; i < int'(MEM_DEPTH); i++)
      mem[i] = DATA_W'((i * 32'h3B3 + seed * 32'h0F0F) ^ 32'h2C4E1);
  endtask

  task automatic push_dump();
    for (int i = 0; i < int'(REG_COUNT); i++)
      exp_q.push_back({(!HAS_MEM && i == int'(REG_COUNT) - 1), 1'b0, MEM_AW'(i), regs[i]});
    if (HAS_MEM)
      for (int i = 0; i < int'(MEM_DEPTH); i++)
        exp_q.push_back({(i == int'(MEM_DEPTH) - 1), 1'b1, MEM_AW'(i), mem[i]});
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk(name, 64'(done), 64'(1));
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ctl"}, 64'({cpu_reset, cpu_clk_en, busy, done}), 64'(4'b1000));
    chk({tag, "_run_count"}, 64'(run_count), 64'(0));
    chk({tag, "_dump"}, 64'({dif.dump_valid, word_now}), 64'(0));
    chk({tag, "_dbg_addr"}, 64'({dbg_reg_addr, dbg_mem_addr}), 64'(0));
  endtask

  // Consumer ready: tied high or pseudo-random, changed just after each edge.
  initial begin
    dif.dump_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      dif.dump_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: score each handshake and check that stalled words stay put.
  initial begin
    word_t prev = '0;
    bit pv = 1'b0, pr = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        pv = 1'b0;
        pr = 1'b0;
      end else begin
        if (pv && !pr)
          chk("stall_hold", 64'({dif.dump_valid, word_now}), 64'({1'b1, prev}));
        if (dif.dump_valid && dif.dump_ready) begin
          words_seen++;
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL extra_word: got %0h expected none", word_now);
          end else begin
            chk("dump_word", 64'(word_now), 64'(exp_q.pop_front()));
          end
        end
        pv   = dif.dump_valid;
        pr   = dif.dump_ready;
        prev = word_now;
      end
    end
  end

  // Count CPU reset-hold and free-running cycles.
  initial forever begin
    @(negedge clk);
    if (reset && cpu_clk_en) begin
      if (cpu_reset) rst_cyc++;
      else           run_cyc++;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int r0, u0, w0, k, g;
    bit found;
    reset = 1'b0; start = 1'b0; cpu_halted = 1'b0;
    load_model(1);
    repeat (3) @(posedge clk);
    #1 check_reset_vals("por");
    @(negedge clk) reset = 1'b1;

    // Full budget run, ready high, start pulse during RUN ignored.
    r0 = rst_cyc; u0 = run_cyc; w0 = words_seen;
    push_dump();
    pulse_start();
    chk("t1_rst_state", 64'({cpu_reset, cpu_clk_en, busy, done}), 64'(4'b1110));
    @(posedge clk); #1;
    chk("t1_run_entry", 64'({cpu_reset, cpu_clk_en}), 64'(2'b01));
    repeat (10) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done("t1_done");
    chk("t1_run_count", 64'(run_count), 64'(100));
    chk("t1_rst_cycles", 64'(rst_cyc - r0), 64'(1));
    chk("t1_run_cycles", 64'(run_cyc - u0), 64'(100));
    chk("t1_words", 64'(words_seen - w0), 64'(NWORDS));
    chk("t1_queue_empty", 64'(exp_q.size()), 64'(0));
    chk("t1_done_ctl", 64'({done, busy, cpu_reset, cpu_clk_en}), 64'(4'b1000));

    // Restart from DONE, halt at RUN cycle 37, random ready, start in dump ignored.
    load_model(7);
    rand_ready = 1'b1;
    u0 = run_cyc; w0 = words_seen;
    push_dump();
    pulse_start();
    chk("t2_count_cleared", 64'(run_count), 64'(0));
    k = 0; g = 0;
    while (k < 37 && g < 500) begin
      @(negedge clk);
      g++;
      if (cpu_clk_en && !cpu_reset) k++;
    end
    cpu_halted = 1'b1;
    @(posedge clk); #1 cpu_halted = 1'b0;
    chk("t2_clk_en_drop", 64'({cpu_clk_en, busy}), 64'(2'b01));
    chk("t2_halt_count", 64'(run_count), 64'(37));
    repeat (7) @(posedge clk);
    #1 start = 1'b1; cpu_halted = 1'b1;
    @(posedge clk); #1 start = 1'b0; cpu_halted = 1'b0;
    wait_done("t2_done");
    chk("t2_run_count", 64'(run_count), 64'(37));
    chk("t2_run_cycles", 64'(run_cyc - u0), 64'(37));
    chk("t2_words", 64'(words_seen - w0), 64'(NWORDS));
    chk("t2_queue_empty", 64'(exp_q.size()), 64'(0));
    rand_ready = 1'b0;

    // Reset in the middle of the dump, then a fresh full run.
    load_model(13);
    push_dump();
    pulse_start();
    found = 1'b0; g = 0;
    while (!found && g < 2000) begin
      @(negedge clk);
      g++;
      found = dif.dump_valid && (dif.dump_is_mem == HAS_MEM) &&
              (dif.dump_addr == MEM_AW'(RST_TGT));
    end
    chk("t3_reach_word", 64'(found), 64'(1));
    #1 reset = 1'b0;
    exp_q.delete();
    #1 check_reset_vals("t3_midreset");
    @(negedge clk) reset = 1'b1;
    u0 = run_cyc; w0 = words_seen;
    push_dump();
    pulse_start();
    wait_done("t3_done");
    chk("t3_run_count", 64'(run_count), 64'(100));
    chk("t3_run_cycles", 64'(run_cyc - u0), 64'(100));
    chk("t3_words", 64'(words_seen - w0), 64'(NWORDS));
    chk("t3_queue_empty", 64'(exp_q.size()), 64'(0));

    repeat (4) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
